fp_alu_arbiter_seq: RTL

Sequencer and round-robin arbiter that shares one combinational 32-bit floating-point ALU between two requesters. It accepts an operation from either requester over a valid/ready handshake and decodes the opcode into the ALU select lines s0..s5. It holds operands stable for a programmable settle time, then captures the result together with IEEE special-value flags. It returns the result with the requester ID over a held response handshake.

---
 rtl/fp_alu_arbiter_seq.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_alu_arbiter_seq.sv
// fp_alu_arbiter_seq
// Shares one combinational 32-bit floating-point ALU between two requesters.
// A round-robin arbiter accepts one operation at a time over valid/ready.
// The opcode is decoded onto the ALU select lines, and the operands are held
// steady for a latency that depends on the operation class. The result is
// then captured with IEEE infinity/NaN flags and returned on a held response
// handshake that is tagged with the requester ID.

module fp_alu_arbiter_seq #(
    parameter int ALU_LAT    = 1,   // settle cycles for simple ops (>= 1)
    parameter int MULDIV_LAT = 4    // settle cycles for multiply/divide (>= 1)
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [5:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_cin,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [5:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_cin,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_cin,
    output logic        alu_s0,
    output logic        alu_s1,
    output logic        alu_s2,
    output logic        alu_s3,
    output logic        alu_s4,
    output logic        alu_s5,
    input  logic [31:0] alu_result,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        rsp_inf,
    output logic        rsp_nan,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // The wait counter must hold the largest "latency - 1" value.
    localparam int MAX_LAT = (ALU_LAT > MULDIV_LAT) ? ALU_LAT : MULDIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] ALU_CNT_INIT    = CNT_W'(ALU_LAT - 1);
    localparam logic [CNT_W-1:0] MULDIV_CNT_INIT = CNT_W'(MULDIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE         = CNT_W'(1);

    // ------------------------------------------------------------------
    // Per-requester views, so decode is written once for both requesters
    // ------------------------------------------------------------------
    logic [1:0]  req_valid;
    logic [5:0]  req_op   [2];
    logic [31:0] req_a    [2];
    logic [31:0] req_b    [2];
    logic [1:0]  req_cin;

    assign req_valid = {req1_valid, req0_valid};
    assign req_op[0] = req0_op;
    assign req_op[1] = req1_op;
    assign req_a[0]  = req0_a;
    assign req_a[1]  = req1_a;
    assign req_b[0]  = req0_b;
    assign req_b[1]  = req1_b;
    assign req_cin   = {req1_cin, req0_cin};

    // Decoded select lines, indexed so that bit k drives alu_sk.
    logic [5:0] dec_sel [2];
    logic [1:0] op_illegal;
    logic [1:0] op_muldiv;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dec
            logic [1:0] unit;
            logic [3:0] func;

            assign unit = req_op[gi][5:4];
            assign func = req_op[gi][3:0];

            // The shift unit only looks at s0, so it is fed from the LSB of
            // func; every other unit gets func MSB-first on s0..s3.
            assign dec_sel[gi][0] = (unit == 2'b00) ? func[0] : func[3];
            assign dec_sel[gi][1] = func[2];
            assign dec_sel[gi][2] = func[1];
            assign dec_sel[gi][3] = func[0];
            assign dec_sel[gi][4] = unit[1];
            assign dec_sel[gi][5] = unit[0];

            // Unit 11 does not exist; unit 10 only defines funcs 0000..1000.
            assign op_illegal[gi] = (unit == 2'b11) ||
                                    ((unit == 2'b10) && (func > 4'd8));

            // Multiply (0111) and divide (1000) need the long settle time.
            assign op_muldiv[gi]  = (unit == 2'b10) &&
                                    ((func == 4'd7) || (func == 4'd8));
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             last_grant_q, last_grant_d;

    logic [31:0]      alu_a_q,      alu_a_d;
    logic [31:0]      alu_b_q,      alu_b_d;
    logic             alu_cin_q,    alu_cin_d;
    logic [5:0]       alu_sel_q,    alu_sel_d;

    logic             rsp_valid_q,  rsp_valid_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [31:0]      rsp_data_q,   rsp_data_d;
    logic             rsp_err_q,    rsp_err_d;
    logic             rsp_inf_q,    rsp_inf_d;
    logic             rsp_nan_q,    rsp_nan_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic grant_valid;
    logic grant_id;

    // Round-robin: on a tie the requester that did not win last time goes.
    always_comb begin
        grant_valid = (state_q == ST_IDLE) && (req_valid != 2'b00);
        if (req_valid == 2'b11) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req_valid[1];
        end
    end

    assign req0_ready = grant_valid && !grant_id && req0_valid;
    assign req1_ready = grant_valid &&  grant_id && req1_valid;

    // Fields of the request being granted this cycle.
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sel_cin;
    logic [5:0]  sel_dec;
    logic        sel_illegal;
    logic        sel_muldiv;

    assign sel_a       = req_a[grant_id];
    assign sel_b       = req_b[grant_id];
    assign sel_cin     = req_cin[grant_id];
    assign sel_dec     = dec_sel[grant_id];
    assign sel_illegal = op_illegal[grant_id];
    assign sel_muldiv  = op_muldiv[grant_id];

    // IEEE-754 single special-value classification of the live ALU result.
    logic res_exp_max;
    logic res_man_zero;
    assign res_exp_max  = (alu_result[30:23] == 8'hFF);
    assign res_man_zero = (alu_result[22:0] == 23'd0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Sequencer: IDLE accepts, WAIT lets the ALU settle, RESP holds the result.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cin_d    = alu_cin_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        rsp_inf_d    = rsp_inf_q;
        rsp_nan_d    = rsp_nan_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    last_grant_d = grant_id;
                    rsp_id_d     = grant_id;
                    if (sel_illegal) begin
                        // Nothing to compute: answer immediately and leave the
                        // ALU inputs exactly as they were.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = 32'd0;
                        rsp_inf_d   = 1'b0;
                        rsp_nan_d   = 1'b0;
                        state_d     = ST_RESP;
                    end else begin
                        alu_a_d   = sel_a;
                        alu_b_d   = sel_b;
                        alu_cin_d = sel_cin;
                        alu_sel_d = sel_dec;
                        cnt_d     = sel_muldiv ? MULDIV_CNT_INIT : ALU_CNT_INIT;
                        state_d   = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = alu_result;
                    rsp_inf_d   = res_exp_max &&  res_man_zero;
                    rsp_nan_d   = res_exp_max && !res_man_zero;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_RESP: begin
                // Completing the response only returns to IDLE; the next
                // accept happens on a later edge.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            alu_a_q      <= 32'd0;
            alu_b_q      <= 32'd0;
            alu_cin_q    <= 1'b0;
            alu_sel_q    <= 6'd0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= 32'd0;
            rsp_err_q    <= 1'b0;
            rsp_inf_q    <= 1'b0;
            rsp_nan_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cin_q    <= alu_cin_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            rsp_inf_q    <= rsp_inf_d;
            rsp_nan_q    <= rsp_nan_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign alu_s0    = alu_sel_q[0];
    assign alu_s1    = alu_sel_q[1];
    assign alu_s2    = alu_sel_q[2];
    assign alu_s3    = alu_sel_q[3];
    assign alu_s4    = alu_sel_q[4];
    assign alu_s5    = alu_sel_q[5];

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_inf   = rsp_inf_q;
    assign rsp_nan   = rsp_nan_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
